// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_add_pkg;

    // Default operand width.
    localparam int unsigned DEFAULT_WIDTH = 8;

    // Controller states; the unused encoding 2'd3 is treated as IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/full_add.sv
// One-bit full adder built from two half-adder cells and an OR.
module full_add (
    input  logic in1,
    input  logic in2,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic ha1_s;
    logic ha1_c;
    logic ha2_c;

    // First half adder on the operand bits, second folds in the carry.
    always_comb begin
        ha1_s = in1 ^ in2;
        ha1_c = in1 & in2;
        sum   = ha1_s ^ cin;
        ha2_c = ha1_s & cin;
        cout  = ha1_c | ha2_c;
    end

endmodule

// File: rtl/serial_add.sv
// Bit-serial adder: accepts an operand pair, adds LSB-first one bit per clock
// through a single full adder with a registered carry, then presents the result.
module serial_add
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_sum;
    logic             fa_cout;

    full_add u_full_add (
        .in1  (a_sh_q[0]),
        .in2  (b_sh_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Next-state and handshake decode; outputs depend only on registered state.
    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        sum_sh_d  = sum_sh_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            RUN: begin
                sum_sh_d = {fa_sum, sum_sh_q[WIDTH-1:1]};
                carry_d  = fa_cout;
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                // IDLE and the unused encoding behave identically.
                in_ready = 1'b1;
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
        endcase
    end

    // State, shift registers, counter and carry flop.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
        end
    end

    // Result is held in the registers until the next RUN overwrites it.
    assign sum  = sum_sh_q;
    assign cout = carry_q;

endmodule

// File: tb/tb_serial_add.sv
// Directed self-checking bench for serial_add (WIDTH=8 and WIDTH=2 builds).
module tb_serial_add;

    logic       clk = 1'b0;
    logic       rst_n;
    // WIDTH=8 instance signals
    logic       in_valid, in_ready, out_valid, out_ready, cout;
    logic [7:0] a, b, sum;
    // WIDTH=2 instance signals
    logic       in_valid2, in_ready2, out_valid2, out_ready2, cout2;
    logic [1:0] a2, b2, sum2;

    int checks = 0;
    int errors = 0;
    int lat;

    serial_add #(.WIDTH(8)) dut8 (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    serial_add #(.WIDTH(2)) dut2 (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .a         (a2),
        .b         (b2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .sum       (sum2),
        .cout      (cout2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Present one operand pair for a single cycle, then wait for out_valid.
    task automatic do_op(input string tag, input logic [7:0] opa, input logic [7:0] opb,
                         input logic [7:0] exp_s, input logic exp_c);
        a = opa;
        b = opb;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, 8);
        chk({tag, "_sum"}, {24'd0, sum}, {24'd0, exp_s});
        chk({tag, "_cout"}, {31'd0, cout}, {31'd0, exp_c});
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = '0; b2 = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_sum", {24'd0, sum}, 0);
        chk("rst_cout", {31'd0, cout}, 0);
        chk("rst_w2_in_ready", {31'd0, in_ready2}, 1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", {31'd0, in_ready}, 1);

        // Basic add, single-cycle out_valid with out_ready held high
        out_ready = 1'b1;
        do_op("a5_5a", 8'hA5, 8'h5A, 8'hFF, 1'b0);
        chk("a5_5a_in_ready_done", {31'd0, in_ready}, 0);
        @(negedge clk);
        chk("a5_5a_ov_drop", {31'd0, out_valid}, 0);
        chk("a5_5a_in_ready_back", {31'd0, in_ready}, 1);
        chk("a5_5a_sum_kept", {24'd0, sum}, 32'hFF);

        // Carry-out, then carry must not leak into the next operation
        do_op("ff_01", 8'hFF, 8'h01, 8'h00, 1'b1);
        @(negedge clk);
        do_op("00_00", 8'h00, 8'h00, 8'h00, 1'b0);
        @(negedge clk);

        // Stall in DONE for 5 cycles
        out_ready = 1'b0;
        do_op("stall", 8'h7F, 8'h01, 8'h80, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_ov", {31'd0, out_valid}, 1);
            chk("stall_sum", {24'd0, sum}, 32'h80);
            chk("stall_cout", {31'd0, cout}, 0);
            chk("stall_in_ready", {31'd0, in_ready}, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_ov", {31'd0, out_valid}, 0);
        chk("stall_release_in_ready", {31'd0, in_ready}, 1);

        // in_valid held high with changing operands during RUN
        a = 8'h12; b = 8'h34; in_valid = 1'b1;
        @(negedge clk);
        chk("hold_accepted", {31'd0, in_ready}, 0);
        for (int i = 0; i < 8; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            @(negedge clk);
        end
        chk("hold_ov", {31'd0, out_valid}, 1);
        chk("hold_sum", {24'd0, sum}, 32'h46);
        chk("hold_cout", {31'd0, cout}, 0);
        a = 8'h90; b = 8'h90;
        @(negedge clk);
        chk("hold_idle_ov", {31'd0, out_valid}, 0);
        chk("hold_idle_in_ready", {31'd0, in_ready}, 1);
        @(negedge clk);
        chk("hold_second_accept", {31'd0, in_ready}, 0);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        chk("hold2_ov_early", {31'd0, out_valid}, 0);
        @(negedge clk);
        chk("hold2_ov", {31'd0, out_valid}, 1);
        chk("hold2_sum", {24'd0, sum}, 32'h20);
        chk("hold2_cout", {31'd0, cout}, 1);
        @(negedge clk);

        // Asynchronous reset during RUN
        a = 8'hA5; b = 8'h5A; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", {31'd0, in_ready}, 1);
        chk("arst_out_valid", {31'd0, out_valid}, 0);
        chk("arst_sum", {24'd0, sum}, 0);
        chk("arst_cout", {31'd0, cout}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op("80_80", 8'h80, 8'h80, 8'h00, 1'b1);
        @(negedge clk);

        // WIDTH=2 instance
        a2 = 2'b11; b2 = 2'b11; in_valid2 = 1'b1; out_ready2 = 1'b1;
        @(negedge clk);
        in_valid2 = 1'b0;
        lat = 0;
        while (out_valid2 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("w2_latency", lat, 2);
        chk("w2_sum", {30'd0, sum2}, 2);
        chk("w2_cout", {31'd0, cout2}, 1);
        @(negedge clk);
        chk("w2_ov_drop", {31'd0, out_valid2}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
